// File: rtl/four_way_toom_cook_seq_if.sv
// Operand/product bundle for the 4-way split GF(2)[x] multiplier.
// start is a one-cycle request taken only when idle; busy/done/c report progress and result.
interface four_way_toom_cook_seq_if #(
    parameter int N = 163
) ();
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] c;

    modport master (output start, a, b, input busy, done, c);
    modport slave  (input start, a, b, output busy, done, c);
endinterface

// File: rtl/four_way_toom_cook_seq.sv
// Sequential carry-less multiplier, 16 limb products digit-serial: latency K+1 edges from start to done.
// No backpressure: start is ignored while busy, c is held until the next product is written.
module four_way_toom_cook_seq #(
    parameter int N = 163,
    parameter int D = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    four_way_toom_cook_seq_if.slave  io
);
    localparam int L  = (N + 3) / 4;
    localparam int K  = (L + D - 1) / D;
    localparam int W  = 2 * L - 1;
    localparam int AW = 4 * L;
    localparam int CN = 2 * N;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, MUL, COMB} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [L-1:0]  a_sh_q [4];
    logic [L-1:0]  a_sh_d [4];
    logic [W-1:0]  b_sh_q [4];
    logic [W-1:0]  b_sh_d [4];
    logic [W-1:0]  acc_q  [4][4];
    logic [W-1:0]  acc_d  [4][4];
    logic [CN-1:0] c_q, c_d;
    logic          done_q, done_d;
    logic [AW-1:0] a_ext, b_ext;
    logic [W-1:0]  p [7];

    assign a_ext   = AW'(io.a);
    assign b_ext   = AW'(io.b);
    assign io.busy = (state_q != IDLE);
    assign io.done = done_q;
    assign io.c    = c_q;

    // Diagonal sums: P_k collects every limb product of weight x^(k*L).
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            p[k] = '0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (i + j == k) p[k] = p[k] ^ acc_q[i][j];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        c_d     = c_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    for (int i = 0; i < 4; i++) begin
                        a_sh_d[i] = a_ext[i*L +: L];
                        b_sh_d[i] = W'(b_ext[i*L +: L]);
                        for (int j = 0; j < 4; j++) acc_d[i][j] = '0;
                    end
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // a limbs shift down and b limbs shift up by D each step, so
                // bit t of a_sh always pairs with b << (s*D + t); digits past
                // the limb top read shifted-in zeros and contribute nothing.
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        for (int t = 0; t < D; t++) begin
                            if (a_sh_q[i][t]) acc_d[i][j] = acc_d[i][j] ^ (b_sh_q[j] << t);
                        end
                    end
                    a_sh_d[i] = a_sh_q[i] >> D;
                    b_sh_d[i] = b_sh_q[i] << D;
                end
                if (cnt_q == CW'(K - 1)) state_d = COMB;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            COMB: begin
                c_d = '0;
                for (int k = 0; k < 7; k++) c_d = c_d ^ (CN'(p[k]) << (k * L));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '{default: '0};
            b_sh_q  <= '{default: '0};
            acc_q   <= '{default: '{default: '0}};
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end
endmodule
